// File: rtl/tnn_seq_pkg.sv
// Shared types and defaults for the TNN frame sequencer.
package tnn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        SETTLE = 2'd2
    } tnn_seq_state_e;

    // Cycles spent after an image so the input FIFO prog_empty flag can catch up.
    localparam int SETTLE_CYC = 2;

    localparam int DEF_PIX_PER_IMG  = 1024;
    localparam int DEF_RES_PER_IMG  = 16;
    localparam int DEF_MAX_INFLIGHT = 2;

    // Counter width for a modulo-n count; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tnn_seq_credit.sv
// Result-side credit tracking: counts result beats per image, keeps the
// in-flight image count and flags result beats that arrive with nothing
// in flight. frames_out and the overflow flag exist only when
// TNN_SEQ_STATS_EN is defined; otherwise they read as zero.
module tnn_seq_credit
    import tnn_seq_pkg::*;
#(
    parameter int RES_PER_IMG = DEF_RES_PER_IMG,
    parameter int CNT_W       = 32
) (
    input  logic             clk_a1,
    input  logic             rst_n_a1,
    input  logic             admit,
    input  logic             res_vld,
    output logic [2:0]       inflight,
    output logic [CNT_W-1:0] frames_out,
    output logic             err_ovf
);

    localparam int RC_W = cnt_width(RES_PER_IMG);

    logic [RC_W-1:0] res_cnt_r;
    logic [2:0]      inflight_r;
    logic [2:0]      inflight_nxt_s;
    logic            accept_s;
    logic            wrap_s;

    // A beat only counts when some image is actually in flight.
    assign accept_s = res_vld & (inflight_r != 3'd0);
    assign wrap_s   = accept_s & (res_cnt_r == RC_W'(RES_PER_IMG - 1));

    // Next in-flight count; admission and completion together cancel out.
    always_comb begin
        inflight_nxt_s = inflight_r;
        case ({admit, wrap_s})
            2'b10:   inflight_nxt_s = inflight_r + 3'd1;
            2'b01:   inflight_nxt_s = inflight_r - 3'd1;
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // Result beat counter and in-flight register.
    always_ff @(posedge clk_a1 or negedge rst_n_a1) begin
        if (!rst_n_a1) begin
            res_cnt_r  <= {RC_W{1'b0}};
            inflight_r <= 3'd0;
        end else begin
            inflight_r <= inflight_nxt_s;
            if (wrap_s) begin
                res_cnt_r <= {RC_W{1'b0}};
            end else if (accept_s) begin
                res_cnt_r <= res_cnt_r + RC_W'(1);
            end
        end
    end

    assign inflight = inflight_r;

`ifdef TNN_SEQ_STATS_EN
    logic [CNT_W-1:0] frames_out_r;
    logic             err_ovf_r;

    // Completed-image count and sticky overflow flag.
    always_ff @(posedge clk_a1 or negedge rst_n_a1) begin
        if (!rst_n_a1) begin
            frames_out_r <= {CNT_W{1'b0}};
            err_ovf_r    <= 1'b0;
        end else begin
            if (wrap_s) begin
                frames_out_r <= frames_out_r + CNT_W'(1);
            end
            if (res_vld && (inflight_r == 3'd0)) begin
                err_ovf_r <= 1'b1;
            end
        end
    end

    assign frames_out = frames_out_r;
    assign err_ovf    = err_ovf_r;
`else
    assign frames_out = {CNT_W{1'b0}};
    assign err_ovf    = 1'b0;
`endif

endmodule

// File: rtl/tnn_frame_sequencer.sv
// Frame-level sequencer between the input FIFO, the TNN and the output FIFO.
// Admits one whole image at a time, bounded by output space and an in-flight
// limit. Optional statistics (frames_in/frames_out/err) are built only when
// the macro TNN_SEQ_STATS_EN is defined.
module tnn_frame_sequencer
    import tnn_seq_pkg::*;
#(
    parameter int PIX_PER_IMG  = DEF_PIX_PER_IMG,
    parameter int RES_PER_IMG  = DEF_RES_PER_IMG,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int CNT_W        = 32
) (
    input  logic             clk_a1,
    input  logic             rst_n_a1,
    input  logic             enable,
    input  logic             img_buffered_n,
    input  logic             pix_vld,
    input  logic             out_space,
    input  logic             res_vld,
    output logic             pix_rd,
    output logic             tnn_in_vld,
    output logic             busy,
    output logic [2:0]       inflight,
    output logic [CNT_W-1:0] frames_in,
    output logic [CNT_W-1:0] frames_out,
    output logic [1:0]       err
);

    localparam int PC_W = cnt_width(PIX_PER_IMG);

    tnn_seq_state_e  state_r;
    logic [PC_W-1:0] pix_cnt_r;
    logic [1:0]      settle_cnt_r;
    logic            rd_q_r;
    logic            admit_s;
    logic            err_ovf_s;

    assign admit_s = (state_r == IDLE) & enable & ~img_buffered_n & out_space
                   & (inflight < 3'(MAX_INFLIGHT));

    // Admission FSM: stream exactly one image, then settle before re-admitting.
    always_ff @(posedge clk_a1 or negedge rst_n_a1) begin
        if (!rst_n_a1) begin
            state_r      <= IDLE;
            pix_cnt_r    <= {PC_W{1'b0}};
            settle_cnt_r <= 2'd0;
            pix_rd       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (admit_s) begin
                        state_r   <= STREAM;
                        pix_cnt_r <= PC_W'(PIX_PER_IMG - 1);
                        pix_rd    <= 1'b1;
                    end
                end
                STREAM: begin
                    if (pix_cnt_r == {PC_W{1'b0}}) begin
                        state_r      <= SETTLE;
                        pix_rd       <= 1'b0;
                        settle_cnt_r <= 2'(SETTLE_CYC - 1);
                    end else begin
                        pix_cnt_r <= pix_cnt_r - PC_W'(1);
                    end
                end
                SETTLE: begin
                    if (settle_cnt_r == 2'd0) begin
                        state_r <= IDLE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    pix_rd  <= 1'b0;
                end
            endcase
        end
    end

    // Read strobe delayed to line up with the FIFO valid.
    always_ff @(posedge clk_a1 or negedge rst_n_a1) begin
        if (!rst_n_a1) begin
            rd_q_r <= 1'b0;
        end else begin
            rd_q_r <= pix_rd;
        end
    end

    assign tnn_in_vld = pix_vld & rd_q_r;
    assign busy       = (state_r != IDLE) | (inflight != 3'd0);

    tnn_seq_credit #(
        .RES_PER_IMG (RES_PER_IMG),
        .CNT_W       (CNT_W)
    ) u_credit (
        .clk_a1     (clk_a1),
        .rst_n_a1   (rst_n_a1),
        .admit      (admit_s),
        .res_vld    (res_vld),
        .inflight   (inflight),
        .frames_out (frames_out),
        .err_ovf    (err_ovf_s)
    );

`ifdef TNN_SEQ_STATS_EN
    logic [CNT_W-1:0] frames_in_r;
    logic             err_unf_r;

    // Admitted-image count and sticky pixel underflow flag.
    always_ff @(posedge clk_a1 or negedge rst_n_a1) begin
        if (!rst_n_a1) begin
            frames_in_r <= {CNT_W{1'b0}};
            err_unf_r   <= 1'b0;
        end else begin
            if (admit_s) begin
                frames_in_r <= frames_in_r + CNT_W'(1);
            end
            if (rd_q_r && !pix_vld) begin
                err_unf_r <= 1'b1;
            end
        end
    end

    assign frames_in = frames_in_r;
    assign err       = {err_ovf_s, err_unf_r};
`else
    assign frames_in = {CNT_W{1'b0}};
    assign err       = {err_ovf_s, 1'b0};
`endif

endmodule

// File: doc/tnn_frame_sequencer.md
# tnn_frame_sequencer

Frame-level controller between the async input FIFO (512→64), the TNN datapath and the output FIFO on the `clk_a1` domain. It admits one whole image at a time into the TNN once the input FIFO reports a full image buffered. It limits the number of images in flight against output-FIFO space and tracks result beats per image. It replaces the free-running 1024-cycle read counter with a credited, restartable sequencer.

## Interface
- `PIX_PER_IMG`, 1024: 64-bit pixel beats read per image; must be ≥2.
- `RES_PER_IMG`, 16: 64-bit result beats the TNN emits per image; must be ≥1.
- `MAX_INFLIGHT`, 2: images admitted but not fully drained; range 1..7.
- `CNT_W`, 32: width of statistics counters.
- `clk_a1` in 1: sole clock.
- `rst_n_a1` in 1: asynchronous active-low reset.
- `enable` in 1: permit new image admission.
- `img_buffered_n` in 1: input FIFO `prog_empty`; low means at least one full image is buffered.
- `pix_vld` in 1: input FIFO `valid`, one cycle after `pix_rd`.
- `out_space` in 1: output FIFO can absorb one image of results (`!prog_full`).
- `res_vld` in 1: TNN `io_dataOut_valid`.
- `pix_rd` out 1: input FIFO `rd_en`; registered.
- `tnn_in_vld` out 1: TNN `io_dataIn_valid`.
- `busy` out 1: state ≠ IDLE or inflight ≠ 0.
- `inflight` out 3: images admitted minus images completed.
- `frames_in` out CNT_W: images admitted.
- `frames_out` out CNT_W: images completed.
- `err` out 2: sticky; [0] pixel underflow, [1] result overflow.

## Operation
- States: IDLE, STREAM, SETTLE.
- IDLE→STREAM when `enable & !img_buffered_n & out_space & inflight < MAX_INFLIGHT`. On that edge: load `pix_cnt = PIX_PER_IMG-1`, set `pix_rd`, increment `inflight` and `frames_in`.
- STREAM: `pix_rd` stays high; `pix_cnt` decrements each cycle. When `pix_cnt == 0`, clear `pix_rd` and go to SETTLE.
- SETTLE lasts exactly 2 cycles, then returns to IDLE. This covers the FIFO `prog_empty` update latency so a stale flag cannot admit a partial image.
- `enable` dropping mid-STREAM does not truncate; the current image completes.
- `tnn_in_vld = pix_vld & rd_q`, where `rd_q` is `pix_rd` delayed one cycle. This path is combinational.
- Underflow: `rd_q & !pix_vld` sets `err[0]`. Sequencing continues regardless.
- Result side: `res_cnt` counts `res_vld` beats modulo `RES_PER_IMG`. On wrap, decrement `inflight` and increment `frames_out`.
- Overflow: `res_vld` while `inflight == 0` sets `err[1]`. The beat is ignored and neither `res_cnt` nor `inflight` changes.
- Admission and completion in the same cycle leave `inflight` unchanged.
- Statistics counters wrap at 2^CNT_W.

## Timing
- Reset values: `pix_rd`=0, `tnn_in_vld`=0, `busy`=0, `inflight`=0, `frames_in`=0, `frames_out`=0, `err`=0. State=IDLE, counters cleared.
- Admission latency: condition true in cycle N gives `pix_rd` high in cycles N+1..N+PIX_PER_IMG.
- The earliest next admission evaluates in cycle N+PIX_PER_IMG+3.
- `tnn_in_vld` follows `pix_vld` with zero latency, in cycles N+2..N+PIX_PER_IMG+1.
- `inflight` and `frames_*` update on the clock edge after the triggering event.
- Reset mid-operation aborts immediately: no drain, all state cleared. Input/output FIFOs are reset by their owners.

## Configuration
- `TNN_SEQ_STATS_EN` defined: `frames_in`, `frames_out` and `err` are implemented as specified.
- `TNN_SEQ_STATS_EN` undefined: these outputs are tied to 0 and their registers are not built.
- Sequencing, `inflight` and `busy` are identical in both builds.

## Structure
- Package `tnn_seq_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, STREAM, SETTLE} tnn_seq_state_e`
  - `localparam SETTLE_CYC = 2`
  - default `PIX_PER_IMG`, `RES_PER_IMG`, `MAX_INFLIGHT` constants
- One sub-module, `tnn_seq_credit`: the `res_cnt` wrap, `inflight` up/down counter, overflow detect and `frames_out`. The top keeps the FSM and pixel counter.

## Test plan
All scenarios use `PIX_PER_IMG=16`, `RES_PER_IMG=4`, `MAX_INFLIGHT=2`.
- Single image: `img_buffered_n` low, `enable`=1, `out_space`=1 → `pix_rd` high exactly 16 cycles; `tnn_in_vld` 16 cycles, 1 cycle later; 4 `res_vld` beats → `inflight` 1→0, `frames_in`=`frames_out`=1.
- Credit limit: 3 images buffered, no `res_vld` → exactly 2 admissions, `inflight`=2, then `pix_rd` stays 0. After 4 `res_vld` beats the third admission occurs.
- Backpressure: `out_space`=0 with image buffered → no `pix_rd`; raising `out_space` → admission on the next edge.
- Simultaneous events: 4th result beat lands on the admission cycle → `inflight` unchanged, `frames_in` and `frames_out` both increment.
- Errors: force `pix_vld`=0 for one STREAM cycle → `err[0]`=1 sticky. `res_vld` with `inflight`=0 → `err[1]`=1, `res_cnt` unchanged.
- Reset mid-STREAM at beat 7 → all outputs 0 asynchronously. After release, a buffered image yields a full 16-beat stream.
